// File: rtl/mem_access_pkg.sv
// Shared constants and helpers for the memory-access stage: load/store codes,
// FSM state encoding and byte-lane strobe helpers.
package mem_access_pkg;

    localparam int STRB_W = 8;
    localparam int OFF_W  = 3;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LW  = 3'd2;
    localparam logic [2:0] LD_LD  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;
    localparam logic [2:0] LD_LWU = 3'd6;

    localparam logic [1:0] ST_SB = 2'd0;
    localparam logic [1:0] ST_SH = 2'd1;
    localparam logic [1:0] ST_SW = 2'd2;
    localparam logic [1:0] ST_SD = 2'd3;

    // Access size uses the same 2-bit encoding for loads (funct3[1:0]) and stores.
    function automatic logic is_aligned(input logic [1:0] size, input logic [OFF_W-1:0] offset);
        logic ok;
        case (size)
            ST_SB:   ok = 1'b1;
            ST_SH:   ok = (offset[0] == 1'b0);
            ST_SW:   ok = (offset[1:0] == 2'b00);
            default: ok = (offset == 3'b000);
        endcase
        return ok;
    endfunction

    function automatic logic [STRB_W-1:0] size_strb(input logic [1:0] size);
        logic [STRB_W-1:0] strb;
        case (size)
            ST_SB:   strb = 8'h01;
            ST_SH:   strb = 8'h03;
            ST_SW:   strb = 8'h0F;
            ST_SD:   strb = 8'hFF;
            default: strb = 8'hFF;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational byte-lane logic: store data/strobe placement and load
// extraction with sign or zero extension.
module mem_align
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [1:0]        st_size,
    input  logic [OFF_W-1:0]  st_offset,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] st_wdata,
    output logic [STRB_W-1:0] st_wstrb,
    input  logic [2:0]        ld_code,
    input  logic [OFF_W-1:0]  ld_offset,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        st_wdata = st_data << {st_offset, 3'b000};
        st_wstrb = size_strb(st_size) << st_offset;
    end

    // The addressed bytes are first moved down to lane 0, then extended.
    always_comb begin
        shifted = ld_rdata >> {ld_offset, 3'b000};
        case (ld_code)
            LD_LB:   ld_data = {{(DATA_W-8){shifted[7]}},   shifted[7:0]};
            LD_LH:   ld_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            LD_LW:   ld_data = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
            LD_LBU:  ld_data = {{(DATA_W-8){1'b0}},         shifted[7:0]};
            LD_LHU:  ld_data = {{(DATA_W-16){1'b0}},        shifted[15:0]};
            LD_LWU:  ld_data = {{(DATA_W-32){1'b0}},        shifted[31:0]};
            LD_LD:   ld_data = shifted;
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: single-outstanding data-bus master with
// alignment checking, upstream stall and a registered write-back result.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [4:0]        rd_addr,
    input  logic              rd_wen,
    input  logic              mem_rd_en,
    input  logic [ADDR_W-1:0] addr_mem_rd,
    input  logic [2:0]        load_code,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] addr_mem_wr,
    input  logic [DATA_W-1:0] data_mem_wr,
    input  logic [1:0]        store_code,
    output logic              mem_stall,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [DATA_W-1:0] dbus_wdata,
    output logic [STRB_W-1:0] dbus_wstrb,
    input  logic              dbus_gnt,
    input  logic              dbus_rvalid,
    input  logic [DATA_W-1:0] dbus_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_wen,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_misalign
);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [2:0]        ld_code_q, ld_code_d;
    logic [4:0]        rd_q, rd_d;
    logic              rd_wen_q, rd_wen_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_wen_q, wb_wen_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              misalign_q, misalign_d;

    logic              is_mem;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_aligned;
    logic              accept;
    logic [DATA_W-1:0] st_wdata;
    logic [STRB_W-1:0] st_wstrb;
    logic [DATA_W-1:0] ld_data;

    // A store takes priority when both enables are raised.
    always_comb begin
        is_mem      = mem_rd_en | mem_wr_en;
        req_addr    = mem_wr_en ? addr_mem_wr : addr_mem_rd;
        req_size    = mem_wr_en ? store_code : load_code[1:0];
        req_aligned = is_aligned(req_size, req_addr[OFF_W-1:0]);
        accept      = (state_q == MEM_IDLE) && ex_valid && is_mem && req_aligned;
    end

    mem_align #(.DATA_W(DATA_W)) u_align (
        .st_size   (store_code),
        .st_offset (addr_mem_wr[OFF_W-1:0]),
        .st_data   (data_mem_wr),
        .st_wdata  (st_wdata),
        .st_wstrb  (st_wstrb),
        .ld_code   (ld_code_q),
        .ld_offset (addr_q[OFF_W-1:0]),
        .ld_rdata  (dbus_rdata),
        .ld_data   (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        ld_code_d  = ld_code_q;
        rd_d       = rd_q;
        rd_wen_d   = rd_wen_q;
        wb_valid_d = 1'b0;
        wb_wen_d   = 1'b0;
        misalign_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;

        case (state_q)
            MEM_IDLE: begin
                if (ex_valid && !is_mem) begin
                    wb_valid_d = 1'b1;
                    wb_wen_d   = rd_wen;
                    wb_rd_d    = rd_addr;
                    wb_data_d  = alu_result;
                end else if (ex_valid && !req_aligned) begin
                    wb_valid_d = 1'b1;
                    misalign_d = 1'b1;
                    wb_rd_d    = rd_addr;
                    wb_data_d  = '0;
                end else if (accept) begin
                    // Full byte address is kept so the load lane offset survives.
                    addr_d    = req_addr;
                    we_d      = mem_wr_en;
                    wdata_d   = mem_wr_en ? st_wdata : '0;
                    wstrb_d   = mem_wr_en ? st_wstrb : '0;
                    ld_code_d = load_code;
                    rd_d      = rd_addr;
                    rd_wen_d  = rd_wen;
                    state_d   = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (dbus_gnt) begin
                    state_d = MEM_RESP;
                end
            end
            MEM_RESP: begin
                if (dbus_rvalid) begin
                    state_d    = MEM_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_wen_d   = !we_q && rd_wen_q;
                    wb_data_d  = we_q ? '0 : ld_data;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= MEM_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            ld_code_q  <= '0;
            rd_q       <= '0;
            rd_wen_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_wen_q   <= 1'b0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            ld_code_q  <= ld_code_d;
            rd_q       <= rd_d;
            rd_wen_q   <= rd_wen_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_wen_q   <= wb_wen_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        mem_stall    = accept || (state_q == MEM_REQ) || ((state_q == MEM_RESP) && !dbus_rvalid);
        dbus_req     = (state_q == MEM_REQ);
        dbus_we      = we_q;
        dbus_addr    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        dbus_wdata   = wdata_q;
        dbus_wstrb   = wstrb_q;
        wb_valid     = wb_valid_q;
        wb_rd        = wb_rd_q;
        wb_wen       = wb_wen_q;
        wb_data      = wb_data_q;
        mem_misalign = misalign_q;
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: a byte-level reference memory predicts
// write-back results and bus transactions; a bus responder and a monitor check them.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [63:0] alu_result;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic        mem_rd_en;
    logic [63:0] addr_mem_rd;
    logic [2:0]  load_code;
    logic        mem_wr_en;
    logic [63:0] addr_mem_wr;
    logic [63:0] data_mem_wr;
    logic [1:0]  store_code;
    logic        mem_stall;
    logic        dbus_req;
    logic        dbus_we;
    logic [63:0] dbus_addr;
    logic [63:0] dbus_wdata;
    logic [7:0]  dbus_wstrb;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [63:0] dbus_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [63:0] wb_data;
    logic        mem_misalign;

    always #5 clk = ~clk;

    mem_access dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .alu_result   (alu_result),
        .rd_addr      (rd_addr),
        .rd_wen       (rd_wen),
        .mem_rd_en    (mem_rd_en),
        .addr_mem_rd  (addr_mem_rd),
        .load_code    (load_code),
        .mem_wr_en    (mem_wr_en),
        .addr_mem_wr  (addr_mem_wr),
        .data_mem_wr  (data_mem_wr),
        .store_code   (store_code),
        .mem_stall    (mem_stall),
        .dbus_req     (dbus_req),
        .dbus_we      (dbus_we),
        .dbus_addr    (dbus_addr),
        .dbus_wdata   (dbus_wdata),
        .dbus_wstrb   (dbus_wstrb),
        .dbus_gnt     (dbus_gnt),
        .dbus_rvalid  (dbus_rvalid),
        .dbus_rdata   (dbus_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_wen       (wb_wen),
        .wb_data      (wb_data),
        .mem_misalign (mem_misalign)
    );

    typedef struct {
        logic        wen;
        logic        misalign;
        logic        chk_rd;
        logic [4:0]  rd;
        logic        chk_data;
        logic [63:0] data;
    } wb_exp_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } bus_exp_t;

    wb_exp_t     wb_q[$];
    bus_exp_t    bus_q[$];
    logic [7:0]  ref_mem [logic [63:0]];
    logic [63:0] bus_mem [logic [63:0]];

    int   checks    = 0;
    int   errors    = 0;
    int   gnt_force = -1;
    logic manual_bus = 1'b0;
    logic man_gnt    = 1'b0;
    logic man_rvalid = 1'b0;
    logic resp_gnt   = 1'b0;
    logic resp_rvalid = 1'b0;

    assign dbus_gnt    = manual_bus ? man_gnt : resp_gnt;
    assign dbus_rvalid = manual_bus ? man_rvalid : resp_rvalid;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] a, input int n, input logic sgn);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(a + 64'(i));
        if (sgn && n < 8 && v[8*n-1]) begin
            for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        bus_mem[a] = d;
        for (int i = 0; i < 8; i++) ref_mem[a + 64'(i)] = d[8*i +: 8];
    endtask

    // Reference model: derive expected write-back and bus transaction, then drive one instruction.
    task automatic applyStimulus(input logic rd_en, input logic wr_en, input logic [63:0] raddr,
                                 input logic [2:0] lcode, input logic [63:0] waddr,
                                 input logic [63:0] wdata, input logic [1:0] scode,
                                 input logic [63:0] alu, input logic [4:0] rd, input logic wen);
        wb_exp_t     we_exp;
        bus_exp_t    be;
        logic [63:0] a;
        int          n;
        int          off;
        logic        is_mem;
        logic        aligned;
        logic        exp_stall;
        logic        done;

        is_mem   = rd_en || wr_en;
        a        = wr_en ? waddr : raddr;
        n        = wr_en ? (1 << scode) : (1 << lcode[1:0]);
        off      = int'(a % 8);
        aligned  = (a % 64'(n)) == 0;
        we_exp   = '{wen: 1'b0, misalign: 1'b0, chk_rd: 1'b0, rd: rd, chk_data: 1'b0, data: '0};
        exp_stall = is_mem && aligned;

        if (!is_mem) begin
            we_exp.wen = wen; we_exp.chk_rd = 1'b1; we_exp.chk_data = 1'b1; we_exp.data = alu;
        end else if (!aligned) begin
            we_exp.misalign = 1'b1; we_exp.chk_data = 1'b1; we_exp.data = '0;
        end else begin
            be = '{addr: a - 64'(off), we: wr_en, strb: '0, wdata: '0};
            if (wr_en) begin
                for (int i = 0; i < n; i++) begin
                    ref_mem[a + 64'(i)] = wdata[8*i +: 8];
                    be.strb[off + i] = 1'b1;
                    be.wdata[8*(off + i) +: 8] = wdata[8*i +: 8];
                end
            end else begin
                we_exp.wen = wen; we_exp.chk_rd = 1'b1; we_exp.chk_data = 1'b1;
                we_exp.data = ref_load(a, n, lcode < 3'd3);
            end
            bus_q.push_back(be);
        end
        wb_q.push_back(we_exp);

        @(posedge clk); #1;
        ex_valid = 1'b1; mem_rd_en = rd_en; mem_wr_en = wr_en;
        addr_mem_rd = raddr; load_code = lcode; addr_mem_wr = waddr;
        data_mem_wr = wdata; store_code = scode; alu_result = alu; rd_addr = rd; rd_wen = wen;
        @(negedge clk);
        checkOutput("stall_issue", 64'(mem_stall), 64'(exp_stall));
        @(posedge clk); #1;
        ex_valid = 1'b0;
        if (!exp_stall) begin
            @(negedge clk);
            checkOutput("wb_next_cycle", 64'(wb_valid), 64'd1);
        end else begin
            done = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (!mem_stall) begin done = 1'b1; break; end
            end
            checkOutput("stall_release", 64'(done), 64'd1);
        end
    endtask

    task automatic checkResetZero(input string tag);
        checkOutput({tag, "_flags"}, 64'({dbus_req, dbus_we, wb_valid, wb_wen, mem_misalign, mem_stall}), 64'd0);
        checkOutput({tag, "_dbus_addr"}, dbus_addr, 64'd0);
        checkOutput({tag, "_dbus_wdata"}, dbus_wdata, 64'd0);
        checkOutput({tag, "_dbus_wstrb"}, 64'(dbus_wstrb), 64'd0);
        checkOutput({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
        checkOutput({tag, "_wb_data"}, wb_data, 64'd0);
    endtask

    // Bus responder: checks each request against the model, then grants and responds.
    initial begin
        bus_exp_t    be;
        int          dly;
        logic [63:0] w;
        dbus_rdata = '0;
        forever begin
            @(negedge clk);
            if (!manual_bus && rst_n && dbus_req) begin
                if (bus_q.size() == 0) begin
                    checkOutput("bus_unexpected_req", 64'(dbus_req), 64'd0);
                    be = '{addr: dbus_addr, we: dbus_we, strb: dbus_wstrb, wdata: dbus_wdata};
                end else begin
                    be = bus_q.pop_front();
                end
                dly = (gnt_force >= 0) ? gnt_force : int'($urandom_range(0, 3));
                for (int c = 0; c <= dly; c++) begin
                    if (c > 0) @(negedge clk);
                    checkOutput("bus_req_held", 64'(dbus_req), 64'd1);
                    checkOutput("bus_addr", dbus_addr, be.addr);
                    checkOutput("bus_we", 64'(dbus_we), 64'(be.we));
                    if (be.we) begin
                        checkOutput("bus_wstrb", 64'(dbus_wstrb), 64'(be.strb));
                        checkOutput("bus_wdata", dbus_wdata, be.wdata);
                    end
                end
                resp_gnt = 1'b1;
                @(negedge clk);
                resp_gnt = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                w = bus_mem.exists(be.addr) ? bus_mem[be.addr] : 64'd0;
                if (be.we) begin
                    for (int i = 0; i < 8; i++) if (dbus_wstrb[i]) w[8*i +: 8] = dbus_wdata[8*i +: 8];
                    bus_mem[be.addr] = w;
                    dbus_rdata = {$urandom, $urandom};
                end else begin
                    dbus_rdata = w;
                end
                resp_rvalid = 1'b1;
                @(negedge clk);
                resp_rvalid = 1'b0;
                dbus_rdata = {$urandom, $urandom};
            end
        end
    end

    // Monitor: every write-back pulse is matched against the oldest expectation.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    checkOutput("wb_unexpected", 64'(wb_valid), 64'd0);
                end else begin
                    e = wb_q.pop_front();
                    checkOutput("wb_wen", 64'(wb_wen), 64'(e.wen));
                    checkOutput("wb_misalign", 64'(mem_misalign), 64'(e.misalign));
                    if (e.chk_rd) checkOutput("wb_rd", 64'(wb_rd), 64'(e.rd));
                    if (e.chk_data) checkOutput("wb_data", wb_data, e.data);
                end
            end else if (mem_misalign) begin
                checkOutput("misalign_without_wb", 64'(mem_misalign), 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0]  lcode;
        logic [1:0]  scode;
        logic [63:0] raddr, waddr, wdata;
        int          kind, n_ld, n_st;
        logic        done;

        rst_n = 1'b0; ex_valid = 1'b0; alu_result = '0; rd_addr = '0; rd_wen = 1'b0;
        mem_rd_en = 1'b0; addr_mem_rd = '0; load_code = '0; mem_wr_en = 1'b0;
        addr_mem_wr = '0; data_mem_wr = '0; store_code = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetZero("reset_init");
        rst_n = 1'b1;

        preload(64'h1000, 64'h0000_0000_8000_0000);
        preload(64'h2000, 64'hDEAD_BEEF_0000_0000);
        for (int w = 0; w < 8; w++) preload(64'h8000 + 64'(8 * w), {$urandom, $urandom});

        $display("[TB] directed cases");
        applyStimulus(1'b0, 1'b0, '0, 3'd0, '0, '0, 2'd0, 64'h1234, 5'd5, 1'b1);
        applyStimulus(1'b1, 1'b0, 64'h1003, 3'd0, '0, '0, 2'd0, '0, 5'd9, 1'b1);
        applyStimulus(1'b1, 1'b0, 64'h2004, 3'd6, '0, '0, 2'd0, '0, 5'd10, 1'b1);
        gnt_force = 2;
        applyStimulus(1'b0, 1'b1, '0, 3'd0, 64'h3006, 64'hABCD, 2'd1, '0, 5'd0, 1'b0);
        gnt_force = -1;
        applyStimulus(1'b0, 1'b1, '0, 3'd0, 64'h4002, 64'h1111_2222, 2'd2, '0, 5'd3, 1'b1);
        applyStimulus(1'b1, 1'b1, 64'h8000, 3'd3, 64'h8010, 64'hFF, 2'd0, '0, 5'd4, 1'b1);

        $display("[TB] randomized cases");
        for (int t = 0; t < 150; t++) begin
            kind  = int'($urandom_range(0, 3));
            lcode = 3'($urandom_range(0, 6));
            scode = 2'($urandom_range(0, 3));
            n_ld  = 1 << lcode[1:0];
            n_st  = 1 << scode;
            raddr = 64'h8000 + 64'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) raddr = raddr & ~64'(n_ld - 1);
            waddr = 64'h8000 + 64'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) waddr = waddr & ~64'(n_st - 1);
            wdata = {$urandom, $urandom};
            if (n_st < 8) wdata = wdata & ((64'h1 << (8 * n_st)) - 64'h1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            applyStimulus(kind == 1 || kind == 3, kind == 2 || kind == 3, raddr, lcode, waddr,
                          wdata, scode, {$urandom, $urandom}, 5'($urandom), 1'($urandom));
        end

        $display("[TB] reset during response");
        manual_bus = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_rd_en = 1'b1; mem_wr_en = 1'b0;
        addr_mem_rd = 64'h1000; load_code = 3'd3; rd_addr = 5'd7; rd_wen = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_test_req", 64'(dbus_req), 64'd1);
        man_gnt = 1'b1;
        @(negedge clk);
        man_gnt = 1'b0;
        checkOutput("rst_test_resp_stall", 64'(mem_stall), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkResetZero("reset_mid");
        rst_n = 1'b1;
        man_rvalid = 1'b1;
        dbus_rdata = 64'hCAFE_F00D_1234_5678;
        @(negedge clk);
        man_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("late_rvalid_no_wb", 64'(wb_valid), 64'd0);
            @(negedge clk);
        end

        done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (wb_q.size() == 0) begin done = 1'b1; break; end
            @(negedge clk);
        end
        checkOutput("wb_queue_drained", 64'(wb_q.size()), 64'd0);
        checkOutput("bus_queue_drained", 64'(bus_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
